// File: rtl/tla_pulse_gen_200_if.sv
//------------------------------------------------------------------------------
// tla_pulse_gen_200_if
// Control/status bundle between the 125->200 MHz crossing stage and the
// 200 MHz pulse/window generator.
//
//   Ga_cap_mode   : 0 = continuous train, 1 = single-shot burst
//   Ga_cap_wdis   : start delay in clocks before the first pulse
//   Ga_cap_plus   : burst pulse count (single-shot only)
//   Ga_com_wdis   : pulse high width minus 1
//   Ga_com_plus   : pulse period in clocks
//   Ga_com_open   : start request, 1-cycle pulse
//   Ga_com_close  : stop request, 1-cycle pulse
//   Ga_pulse      : strobe output
//   Ga_edge       : 1-cycle flag on each strobe rising edge
//   Ga_pulse_idx  : completed periods since the last accepted open
//   Ga_wdis       : status {config error, done, busy}
//
// master = control side (crossing stage / bench), slave = generator.
//------------------------------------------------------------------------------
`timescale 1ns/1ps

interface tla_pulse_gen_200_if #(
  parameter int TOP0_0 = 3,
  parameter int LDD0_0 = 32
);
  logic              Ga_cap_mode;
  logic [TOP0_0-1:0] Ga_cap_wdis;
  logic [LDD0_0-1:0] Ga_cap_plus;
  logic [TOP0_0-1:0] Ga_com_wdis;
  logic [LDD0_0-1:0] Ga_com_plus;
  logic              Ga_com_open;
  logic              Ga_com_close;
  logic              Ga_pulse;
  logic              Ga_edge;
  logic [LDD0_0-1:0] Ga_pulse_idx;
  logic [TOP0_0-1:0] Ga_wdis;

  modport master (
    output Ga_cap_mode, Ga_cap_wdis, Ga_cap_plus,
    output Ga_com_wdis, Ga_com_plus, Ga_com_open, Ga_com_close,
    input  Ga_pulse, Ga_edge, Ga_pulse_idx, Ga_wdis
  );

  modport slave (
    input  Ga_cap_mode, Ga_cap_wdis, Ga_cap_plus,
    input  Ga_com_wdis, Ga_com_plus, Ga_com_open, Ga_com_close,
    output Ga_pulse, Ga_edge, Ga_pulse_idx, Ga_wdis
  );
endinterface

// File: rtl/tla_pulse_gen_200.sv
//------------------------------------------------------------------------------
// tla_pulse_gen_200
// 200 MHz pulse/window generator. After an accepted open it waits a start
// delay, then emits a strobe train of period P with W high clocks, either
// continuously or as a burst of N pulses. Status is returned on Ga_wdis.
//
// Ports:
//   Ga_clk200 : 200 MHz clock (only clock)
//   Ga_rst    : synchronous active-high reset
//   bus       : control/status bundle (slave side), see tla_pulse_gen_200_if
//
// Timing: open/close are captured in an input register first, so an open
// sampled at edge k acts on the FSM at edge k+1; all outputs are registered
// from the FSM's next-state decision at that same edge.
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module tla_pulse_gen_200 #(
  parameter int TOP0_0 = 3,
  parameter int LDD0_0 = 32
) (
  input  logic Ga_clk200,
  input  logic Ga_rst,
  tla_pulse_gen_200_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_HIGH  = 2'd2,
    ST_LOW   = 2'd3
  } state_e;

  localparam logic [LDD0_0-1:0] ONE = {{(LDD0_0-1){1'b0}}, 1'b1};

  // Config is unusable if the period is zero, leaves no low time, or a
  // burst asks for zero pulses.
  function automatic logic cfg_invalid(
    input logic [LDD0_0-1:0] per,
    input logic [LDD0_0-1:0] wid,
    input logic              mode,
    input logic [LDD0_0-1:0] num
  );
    logic bad;
    bad = 1'b0;
    if (per == '0) begin
      bad = 1'b1;
    end else if (per <= wid) begin
      bad = 1'b1;
    end else if (mode && (num == '0)) begin
      bad = 1'b1;
    end else begin
      bad = 1'b0;
    end
    return bad;
  endfunction

  // FSM / output registers
  state_e            state_q;
  logic              open_q;
  logic              close_q;
  logic              mode_q;
  logic [TOP0_0-1:0] dly_q;
  logic [LDD0_0-1:0] nb_q;
  logic [LDD0_0-1:0] per_q;
  logic [LDD0_0-1:0] wid_q;
  logic [LDD0_0-1:0] cnt_q;
  logic [LDD0_0-1:0] idx_q;
  logic              pulse_q;
  logic              edge_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;

  // Combinational helpers
  logic [LDD0_0-1:0] wid_in_s;
  logic              cfg_bad_s;
  logic [LDD0_0-1:0] low_len_s;
  logic [LDD0_0-1:0] cnt_inc_s;
  logic              dly_last_s;
  logic              high_last_s;
  logic              low_last_s;
  logic [LDD0_0-1:0] idx_d;

  // High width is stored as com_wdis+1 so the phase comparisons use W directly.
  assign wid_in_s  = {{(LDD0_0-TOP0_0){1'b0}}, bus.Ga_com_wdis} + ONE;
  assign cfg_bad_s = cfg_invalid(bus.Ga_com_plus, wid_in_s, bus.Ga_cap_mode, bus.Ga_cap_plus);

  // Validity check guarantees per_q > wid_q whenever LOW is reachable,
  // so this subtraction cannot wrap.
  assign low_len_s   = per_q - wid_q;
  assign cnt_inc_s   = cnt_q + ONE;
  assign dly_last_s  = (cnt_inc_s == {{(LDD0_0-TOP0_0){1'b0}}, dly_q});
  assign high_last_s = (cnt_inc_s == wid_q);
  assign low_last_s  = (cnt_inc_s == low_len_s);
  assign idx_d       = idx_q + ONE;

  // Pulse FSM with config latch, period counter, index and status flags.
  always_ff @(posedge Ga_clk200) begin
    if (Ga_rst) begin
      state_q <= ST_IDLE;
      open_q  <= 1'b0;
      close_q <= 1'b0;
      mode_q  <= 1'b0;
      dly_q   <= '0;
      nb_q    <= '0;
      per_q   <= '0;
      wid_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      pulse_q <= 1'b0;
      edge_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      open_q  <= bus.Ga_com_open;
      close_q <= bus.Ga_com_close;
      edge_q  <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          pulse_q <= 1'b0;
          busy_q  <= 1'b0;
          cnt_q   <= '0;
          // Close wins over a simultaneous open: nothing is latched.
          if (open_q && !close_q) begin
            mode_q <= bus.Ga_cap_mode;
            dly_q  <= bus.Ga_cap_wdis;
            nb_q   <= bus.Ga_cap_plus;
            per_q  <= bus.Ga_com_plus;
            wid_q  <= wid_in_s;
            idx_q  <= '0;
            done_q <= 1'b0;
            err_q  <= cfg_bad_s;
            if (cfg_bad_s) begin
              state_q <= ST_IDLE;
            end else if (bus.Ga_cap_wdis == '0) begin
              state_q <= ST_HIGH;
              pulse_q <= 1'b1;
              edge_q  <= 1'b1;
              busy_q  <= 1'b1;
            end else begin
              state_q <= ST_DELAY;
              busy_q  <= 1'b1;
            end
          end else begin
            state_q <= ST_IDLE;
          end
        end

        ST_DELAY: begin
          if (close_q) begin
            state_q <= ST_IDLE;
            pulse_q <= 1'b0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end else if (dly_last_s) begin
            state_q <= ST_HIGH;
            pulse_q <= 1'b1;
            edge_q  <= 1'b1;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_inc_s;
          end
        end

        ST_HIGH: begin
          if (close_q) begin
            state_q <= ST_IDLE;
            pulse_q <= 1'b0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end else if (high_last_s) begin
            state_q <= ST_LOW;
            pulse_q <= 1'b0;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_inc_s;
          end
        end

        ST_LOW: begin
          if (close_q) begin
            // Stop without completing the period: index is held as-is.
            state_q <= ST_IDLE;
            pulse_q <= 1'b0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end else if (low_last_s) begin
            idx_q <= idx_d;
            cnt_q <= '0;
            if (mode_q && (idx_d == nb_q)) begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_HIGH;
              pulse_q <= 1'b1;
              edge_q  <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_inc_s;
          end
        end

        default: begin
          state_q <= ST_IDLE;
          pulse_q <= 1'b0;
          busy_q  <= 1'b0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign bus.Ga_pulse     = pulse_q;
  assign bus.Ga_edge      = edge_q;
  assign bus.Ga_pulse_idx = idx_q;
  assign bus.Ga_wdis      = {err_q, done_q, busy_q};

endmodule

// File: tb/tb_tla_pulse_gen_200.sv
//------------------------------------------------------------------------------
// tb_tla_pulse_gen_200
// Scoreboard bench: a reference model computes, from the run parameters and
// the cycle count since start, what every output should be after each clock
// edge and queues it; a monitor on the falling edge pops and compares.
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_tla_pulse_gen_200;
  localparam int TW = 3;
  localparam int LW = 32;

  typedef struct packed {
    logic          pulse;
    logic          edg;
    logic [LW-1:0] idx;
    logic [TW-1:0] wdis;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #2.5 clk = ~clk;

  tla_pulse_gen_200_if #(.TOP0_0(TW), .LDD0_0(LW)) bus_if ();

  tla_pulse_gen_200 #(.TOP0_0(TW), .LDD0_0(LW)) dut (
    .Ga_clk200 (clk),
    .Ga_rst    (rst),
    .bus       (bus_if)
  );

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   waited = 0;

  // ---------------- reference model ----------------
  int cyc = 0;
  bit run = 1'b0;
  int st = 0;
  int m_p = 0, m_w = 0, m_d = 0, m_n = 0;
  bit m_m = 1'b0;
  bit m_done = 1'b0, m_err = 1'b0;
  int held = 0;
  bit p_open = 1'b0, p_close = 1'b0;
  int c_p = 0, c_w = 0, c_d = 0, c_n = 0;
  bit c_m = 1'b0;

  always @(posedge clk) begin
    exp_t e;
    int t, u;
    cyc = cyc + 1;
    if (rst) begin
      run = 1'b0; m_done = 1'b0; m_err = 1'b0; held = 0;
      p_open = 1'b0; p_close = 1'b0;
    end else begin
      // Requests seen at the previous edge take effect at this one.
      if (p_close) begin
        run = 1'b0;
      end else if (p_open && !run) begin
        m_p = c_p; m_w = c_w; m_d = c_d; m_n = c_n; m_m = c_m;
        m_done = 1'b0; held = 0;
        m_err = (m_p == 0) || (m_p <= m_w) || (m_m && m_n == 0);
        if (!m_err) begin
          run = 1'b1;
          st  = cyc;
        end
      end
      if (run && m_m && (cyc - st) >= m_d + m_n * m_p) begin
        run = 1'b0; m_done = 1'b1; held = m_n;
      end
      p_open  = bus_if.Ga_com_open;
      p_close = bus_if.Ga_com_close;
      c_p = int'(bus_if.Ga_com_plus);
      c_w = int'(bus_if.Ga_com_wdis) + 1;
      c_d = int'(bus_if.Ga_cap_wdis);
      c_n = int'(bus_if.Ga_cap_plus);
      c_m = bus_if.Ga_cap_mode;
    end
    e.pulse = 1'b0;
    e.edg   = 1'b0;
    if (run) begin
      t = cyc - st;
      if (t < m_d) begin
        held = 0;
      end else begin
        u = t - m_d;
        held = u / m_p;
        e.pulse = ((u % m_p) < m_w);
        e.edg   = ((u % m_p) == 0);
      end
    end
    e.idx  = LW'(held);
    e.wdis = {m_err, m_done, run};
    exp_q.push_back(e);
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tests = tests + 1;
      if ({bus_if.Ga_pulse, bus_if.Ga_edge, bus_if.Ga_pulse_idx, bus_if.Ga_wdis} !== e) begin
        fails = fails + 1;
        $display("FAIL outputs@cyc%0d: got pulse=%0b edge=%0b idx=%0d wdis=%b, expected pulse=%0b edge=%0b idx=%0d wdis=%b",
                 cyc, bus_if.Ga_pulse, bus_if.Ga_edge, bus_if.Ga_pulse_idx, bus_if.Ga_wdis,
                 e.pulse, e.edg, e.idx, e.wdis);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_cfg(input bit m, input int capw, input int capp, input int comw, input int comp);
    bus_if.Ga_cap_mode = m;
    bus_if.Ga_cap_wdis = TW'(capw);
    bus_if.Ga_cap_plus = LW'(capp);
    bus_if.Ga_com_wdis = TW'(comw);
    bus_if.Ga_com_plus = LW'(comp);
  endtask

  task automatic pulse_ctl(input bit op, input bit cl, input bit rs);
    bus_if.Ga_com_open  = op;
    bus_if.Ga_com_close = cl;
    rst = rs;
    @(negedge clk);
    bus_if.Ga_com_open  = 1'b0;
    bus_if.Ga_com_close = 1'b0;
    rst = 1'b0;
  endtask

  initial begin
    bus_if.Ga_com_open  = 1'b0;
    bus_if.Ga_com_close = 1'b0;
    set_cfg(1'b0, 0, 0, 0, 0);
    rst = 1'b1;
    cycles(3);
    tests = tests + 1;
    if ((bus_if.Ga_pulse !== 1'b0) || (bus_if.Ga_edge !== 1'b0) ||
        (bus_if.Ga_pulse_idx !== {LW{1'b0}}) || (bus_if.Ga_wdis !== {TW{1'b0}})) begin
      fails = fails + 1;
      $display("FAIL reset state: pulse=%0b edge=%0b idx=%0d wdis=%b",
               bus_if.Ga_pulse, bus_if.Ga_edge, bus_if.Ga_pulse_idx, bus_if.Ga_wdis);
    end
    rst = 1'b0;
    cycles(2);

    // Continuous: P=10, W=3, D=0
    set_cfg(1'b0, 0, 0, 2, 10);
    pulse_ctl(1'b1, 1'b0, 1'b0);
    waited = 0;
    while ((bus_if.Ga_edge !== 1'b1) && (waited < 20)) begin
      @(negedge clk);
      waited = waited + 1;
    end
    tests = tests + 1;
    if (bus_if.Ga_edge !== 1'b1) begin
      fails = fails + 1;
      $display("FAIL wait for first Ga_edge expired after %0d cycles", waited);
    end
    cycles(45 - waited);
    pulse_ctl(1'b0, 1'b1, 1'b0);
    cycles(3);

    // Single-shot burst: N=4, P=8, W=1, D=5
    set_cfg(1'b1, 5, 4, 0, 8);
    pulse_ctl(1'b1, 1'b0, 1'b0);
    cycles(45);

    // Close in 2nd HIGH cycle of the third period (P=10, W=3)
    set_cfg(1'b0, 0, 0, 2, 10);
    pulse_ctl(1'b1, 1'b0, 1'b0);
    cycles(22);
    pulse_ctl(1'b0, 1'b1, 1'b0);
    cycles(4);

    // Invalid P=3, W=3, then valid P=4
    set_cfg(1'b0, 0, 0, 2, 3);
    pulse_ctl(1'b1, 1'b0, 1'b0);
    cycles(5);
    set_cfg(1'b0, 0, 0, 2, 4);
    pulse_ctl(1'b1, 1'b0, 1'b0);
    cycles(12);
    pulse_ctl(1'b0, 1'b1, 1'b0);
    cycles(3);

    // Open+close together in IDLE, then open while running with new P
    pulse_ctl(1'b1, 1'b1, 1'b0);
    cycles(3);
    set_cfg(1'b0, 0, 0, 1, 6);
    pulse_ctl(1'b1, 1'b0, 1'b0);
    cycles(5);
    set_cfg(1'b0, 0, 0, 1, 12);
    pulse_ctl(1'b1, 1'b0, 1'b0);
    cycles(20);
    pulse_ctl(1'b0, 1'b1, 1'b0);
    cycles(3);

    // Reset mid-LOW in a burst, then restart
    set_cfg(1'b1, 0, 3, 1, 10);
    pulse_ctl(1'b1, 1'b0, 1'b0);
    cycles(15);
    pulse_ctl(1'b0, 1'b0, 1'b1);
    cycles(2);
    pulse_ctl(1'b1, 1'b0, 1'b0);
    cycles(35);

    // Randomized runs
    for (int it = 0; it < 40; it++) begin
      set_cfg(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), int'($urandom_range(0, 4)),
              int'($urandom_range(0, 7)), int'($urandom_range(0, 14)));
      pulse_ctl(1'b1, ($urandom_range(0, 9) == 0), 1'b0);
      for (int c = 0; c < int'($urandom_range(5, 60)); c++) begin
        int r;
        r = int'($urandom_range(0, 99));
        pulse_ctl(r < 5, (r >= 5) && (r < 8), r == 8);
      end
    end
    cycles(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
